// File: rtl/ysyx_22050598_ifu.sv
// Instruction fetch unit: owns the PC, fetches one 32-bit word per request and
// holds {pc, inst} in a single-entry buffer until decode consumes it.
module ysyx_22050598_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        redir_valid,
  input  logic [63:0] redir_pc,
  input  logic        halt,
  output logic        halted
);

  // Valid/ready: a transfer happens on a rising edge where both valid and
  // ready are high; valid never depends combinationally on ready.
  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        drop_q, drop_d;
  logic [63:0] redir_tgt;

  assign redir_tgt = {redir_pc[63:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      buf_pc_q   <= 64'h0;
      buf_inst_q <= 32'h0000_0013;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    drop_d     = drop_q;
    if (halt) begin
      // A handshake in the same cycle as halt still retires the buffer.
      state_d = S_HALTED;
      drop_d  = 1'b0;
      if (state_q == S_HOLD && if_ready) pc_d = pc_q + 64'd4;
    end else begin
      case (state_q)
        S_REQ: begin
          if (redir_valid) begin
            pc_d = redir_tgt;
            if (imem_req_ready) begin
              drop_d  = 1'b1;
              state_d = S_WAIT;
            end
          end else if (imem_req_ready) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (redir_valid) begin
            pc_d = redir_tgt;
            if (imem_resp_valid) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              drop_d = 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              buf_pc_d   = pc_q;
              buf_inst_d = imem_resp_data;
              state_d    = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redir_valid) begin
            pc_d    = redir_tgt;
            state_d = S_REQ;
          end else if (if_ready) begin
            pc_d    = pc_q + 64'd4;
            state_d = S_REQ;
          end
        end
        default: begin
          // Any late response is simply ignored here.
          drop_d  = 1'b0;
          state_d = S_HALTED;
        end
      endcase
    end
  end

  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    imem_req_addr  = pc_q;
    if_valid       = (state_q == S_HOLD);
    halted         = (state_q == S_HALTED);
    if_pc          = buf_pc_q;
    if_inst        = buf_inst_q;
  end

endmodule
